pixel_frame_sequencer: RTL

Parametrised next-generation pixel-array control FSM. Drives the global erase/expose/convert phases and the read-out address scan for a NUM_ROWS x NUM_COLS sensor. Supports non-square arrays, a runtime exposure time, multi-channel column read-out, a start/busy/frame_done handshake, continuous mode and abort. Sits between the top-level controller and the pixel array / column read-out logic.

---
 rtl/pixel_seq_pkg.sv | 7 +
 rtl/pixel_frame_sequencer_if.sv | 28 ++
 rtl/pixel_addr_scan.sv | 36 +++
 rtl/pixel_frame_sequencer.sv | 84 ++++++++
 4 files changed

// File: rtl/pixel_seq_pkg.sv
// pixel_seq_pkg: shared state encoding and address-width helper for the pixel frame sequencer
package pixel_seq_pkg;
   typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, DONE} state_t;
   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/pixel_frame_sequencer_if.sv
// pixel_frame_sequencer_if: controller handshake and pixel-array drive bundle; frame_count exists only with PIXEL_FRAME_CNT_EN
interface pixel_frame_sequencer_if
   import pixel_seq_pkg::*;
#(
   parameter int NUM_ROWS = 8,
   parameter int NUM_COLS = 8,
   parameter int EXPOSE_W = 16
);
   localparam int ROW_W = addr_w(NUM_ROWS);
   localparam int COL_W = addr_w(NUM_COLS);
   logic start, continuous, abort;
   logic [EXPOSE_W-1:0] expose_time;
   logic erase, expose, convert, read, busy, frame_done;
   logic [ROW_W-1:0] row_addr;
   logic [COL_W-1:0] col_addr;
`ifdef PIXEL_FRAME_CNT_EN
   logic [15:0] frame_count;
   modport master (output start, continuous, abort, expose_time,
                   input erase, expose, convert, read, busy, frame_done, row_addr, col_addr, frame_count);
   modport slave  (input start, continuous, abort, expose_time,
                   output erase, expose, convert, read, busy, frame_done, row_addr, col_addr, frame_count);
`else
   modport master (output start, continuous, abort, expose_time,
                   input erase, expose, convert, read, busy, frame_done, row_addr, col_addr);
   modport slave  (input start, continuous, abort, expose_time,
                   output erase, expose, convert, read, busy, frame_done, row_addr, col_addr);
`endif
endinterface

// File: rtl/pixel_addr_scan.sv
// pixel_addr_scan: row-major read-out address scan stepping NUM_CH columns per advance
module pixel_addr_scan
   import pixel_seq_pkg::*;
#(
   parameter int NUM_ROWS = 8,
   parameter int NUM_COLS = 8,
   parameter int NUM_CH   = 1,
   localparam int ROW_W   = addr_w(NUM_ROWS),
   localparam int COL_W   = addr_w(NUM_COLS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_advance,
   output logic [ROW_W-1:0] o_row_addr,
   output logic [COL_W-1:0] o_col_addr,
   output logic             o_last
);
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;
   logic             w_col_end;
   assign w_col_end  = r_col == COL_W'(NUM_COLS - NUM_CH);
   assign o_last     = w_col_end && (r_row == ROW_W'(NUM_ROWS - 1));
   assign o_row_addr = r_row;
   assign o_col_addr = r_col;
   // step one column group per advance; the last group wraps the whole scan back to the origin
   always_ff @(posedge clk) begin
      if (reset || i_clear || (i_advance && o_last)) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_advance) begin
         r_col <= w_col_end ? '0 : r_col + COL_W'(NUM_CH);
         r_row <= w_col_end ? r_row + ROW_W'(1) : r_row;
      end
   end
endmodule

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer: erase/expose/convert/read frame FSM for a NUM_ROWS x NUM_COLS array; PIXEL_FRAME_CNT_EN adds a completed-frame counter
module pixel_frame_sequencer
   import pixel_seq_pkg::*;
#(
   parameter int NUM_ROWS     = 8,
   parameter int NUM_COLS     = 8,
   parameter int NUM_CH       = 1,
   parameter int ERASE_CYCLES = 5,
   parameter int CONV_CYCLES  = 8,
   parameter int EXPOSE_W     = 16
) (
   input logic                    clk,
   input logic                    reset,
   pixel_frame_sequencer_if.slave bus
);
   localparam int EXP_MAX = (1 << EXPOSE_W) - 1;
   localparam int PH_MAX  = (ERASE_CYCLES > CONV_CYCLES) ? ERASE_CYCLES : CONV_CYCLES;
   localparam int CNT_MAX = (PH_MAX > EXP_MAX) ? PH_MAX : EXP_MAX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   state_t              r_state, w_state;
   logic [CNT_W-1:0]    r_cnt, w_load;
   logic [EXPOSE_W-1:0] r_exp, w_exp_in;
   logic                w_enter, w_clear, w_advance, w_last;
   assign w_exp_in  = (bus.expose_time == '0) ? EXPOSE_W'(1) : bus.expose_time;
   assign w_enter   = w_state != r_state;
   assign w_clear   = w_state != READ;
   assign w_advance = r_state == READ;
   // next state: each timed phase ends when its down-counter reaches zero; abort overrides every transition
   always_comb begin
      w_state = r_state;
      case (r_state)
         IDLE:    w_state = bus.start ? ERASE : IDLE;
         ERASE:   w_state = (r_cnt == '0) ? EXPOSE : ERASE;
         EXPOSE:  w_state = (r_cnt == '0) ? CONVERT : EXPOSE;
         CONVERT: w_state = (r_cnt == '0) ? READ : CONVERT;
         READ:    w_state = w_last ? DONE : READ;
         DONE:    w_state = bus.continuous ? ERASE : IDLE;
         default: w_state = IDLE;
      endcase
      if (bus.abort) w_state = IDLE;
      w_load = (w_state == ERASE)   ? CNT_W'(ERASE_CYCLES - 1) :
               (w_state == EXPOSE)  ? CNT_W'(r_exp - EXPOSE_W'(1)) :
               (w_state == CONVERT) ? CNT_W'(CONV_CYCLES - 1) : '0;
   end
   // state register, phase counter (loaded on every phase entry) and exposure latch taken on entry to ERASE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_exp   <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_enter ? w_load : (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
         r_exp   <= (w_enter && w_state == ERASE) ? w_exp_in : r_exp;
      end
   end
   pixel_addr_scan #(
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS),
      .NUM_CH   (NUM_CH)
   ) u_scan (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_clear),
      .i_advance  (w_advance),
      .o_row_addr (bus.row_addr),
      .o_col_addr (bus.col_addr),
      .o_last     (w_last)
   );
   assign bus.erase      = r_state == ERASE;
   assign bus.expose     = r_state == EXPOSE;
   assign bus.convert    = r_state == CONVERT;
   assign bus.read       = r_state == READ;
   assign bus.frame_done = r_state == DONE;
   assign bus.busy       = r_state != IDLE;
`ifdef PIXEL_FRAME_CNT_EN
   logic [15:0] r_frame_count;
   // count frames that reach DONE; aborted frames never get there
   always_ff @(posedge clk) begin
      r_frame_count <= reset ? 16'd0 : (r_state == DONE) ? r_frame_count + 16'd1 : r_frame_count;
   end
   assign bus.frame_count = r_frame_count;
`endif
endmodule
